// File: rtl/usb_cdc_in_arbiter.sv
// Round-robin arbiter that shares the usb_cdc IN byte stream between N_REQ producers; a grant is held for a whole burst.
// One cycle from request to grant and one IDLE cycle between bursts; in_ready_i passes straight to the granted requester.
module usb_cdc_in_arbiter #(
   parameter int N_REQ       = 2,
   parameter int MAX_BURST   = 8,
   parameter int IDLE_CYCLES = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [8*N_REQ-1:0] req_data_i,
   input  logic [N_REQ-1:0]   req_valid_i,
   input  logic [N_REQ-1:0]   req_last_i,
   output logic [N_REQ-1:0]   req_ready_o,
   output logic [7:0]         in_data_o,
   output logic               in_valid_o,
   input  logic               in_ready_i,
   output logic [N_REQ-1:0]   grant_o,
   output logic               busy_o
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t        state;
   logic [PW-1:0] ptr;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idl;

   logic [PW-1:0] g_idx;
   logic          g_valid;
   logic          g_last;
   logic [7:0]    g_data;
   logic          nxt_found;
   logic [PW-1:0] nxt_idx;
   logic          xfer;
   logic          burst_end;
   logic          timeout;

   // A zero grant vector selects nothing, so the IN side reads as idle outside GRANT.
   always_comb begin
      g_idx   = '0;
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = 8'h00;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_o[k]) begin
            g_idx   = PW'(k);
            g_valid = req_valid_i[k];
            g_last  = req_last_i[k];
            g_data  = req_data_i[8*k +: 8];
         end
      end
   end

   // Search starts just after the last winner, so that winner is considered last.
   always_comb begin : arb_search
      int j;
      nxt_found = 1'b0;
      nxt_idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         j = (int'(ptr) + i) % N_REQ;
         if (!nxt_found && req_valid_i[j]) begin
            nxt_found = 1'b1;
            nxt_idx   = PW'(j);
         end
      end
   end

   assign in_valid_o  = g_valid;
   assign in_data_o   = g_data;
   assign req_ready_o = grant_o & {N_REQ{in_ready_i}};
   assign busy_o      = |grant_o;

   assign xfer      = g_valid & in_ready_i;
   assign burst_end = xfer & (g_last | (cnt == CW'(MAX_BURST - 1)));
   // Fires on the idle cycle that brings idl to IDLE_CYCLES; a stalled valid byte clears idl instead.
   assign timeout   = (IDLE_CYCLES > 0) && !g_valid && (idl == IW'(IDLE_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         grant_o <= '0;
         ptr     <= PW'(N_REQ - 1);
         cnt     <= '0;
         idl     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (nxt_found) begin
                  state   <= S_GRANT;
                  grant_o <= N_REQ'(1) << nxt_idx;
                  cnt     <= '0;
                  idl     <= '0;
               end
            end
            S_GRANT: begin
               if (burst_end || timeout) begin
                  state   <= S_IDLE;
                  grant_o <= '0;
                  ptr     <= g_idx;
                  cnt     <= '0;
                  idl     <= '0;
               end else begin
                  if (xfer)
                     cnt <= cnt + 1'b1;
                  if (g_valid)
                     idl <= '0;
                  else if (idl != '1)
                     idl <= idl + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               grant_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/usb_cdc_in_arbiter.md
# usb_cdc_in_arbiter

Round-robin arbiter that shares the single IN bulk byte stream of `usb_cdc` (`in_data_i`/`in_valid_i`/`in_ready_o`) between N independent byte producers.

- Grants are held for a whole burst, so bytes from different requesters never interleave within one USB packet.
- A burst ends on the requester's `last` flag, on reaching the bulk max packet size, or after an idle timeout.
- The block sits between application sources (loopback echo, status/debug reporters) and the `usb_cdc` IN interface, in the `usb_cdc` clock domain.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2..8).
- `MAX_BURST`, 8, max bytes per grant; set equal to `IN_BULK_MAXPACKETSIZE`.
- `IDLE_CYCLES`, 64, cycles a granted requester may hold `valid` low before the grant is revoked; 0 disables the timeout.

Ports:
- `clk_i`  in  1  block clock, same clock as `usb_cdc` `clk_i`.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_data_i`  in  8*N_REQ  byte from requester k, carried on bits [8k+7:8k].
- `req_valid_i`  in  N_REQ  requester k has a byte.
- `req_last_i`  in  N_REQ  the current byte of requester k ends its burst.
- `req_ready_o`  out  N_REQ  byte of requester k is accepted this cycle.
- `in_data_o`  out  8  to `usb_cdc` `in_data_i`.
- `in_valid_o`  out  1  to `usb_cdc` `in_valid_i`.
- `in_ready_i`  in  1  from `usb_cdc` `in_ready_o`.
- `grant_o`  out  N_REQ  one-hot registered grant; all zero when idle.
- `busy_o`  out  1  a grant is active (= `|grant_o`).

## Operation
- **States:** `IDLE` and `GRANT`. The registered state consists of `grant_o`, the round-robin pointer `ptr`, the burst counter `cnt` ($clog2(MAX_BURST+1) bits) and the idle counter `idl` ($clog2(IDLE_CYCLES+1) bits, minimum 1).
- **IDLE:**
  - If any `req_valid_i` bit is high, select the first valid requester searching `ptr+1, ptr+2, …`, wrapping modulo `N_REQ`.
  - Load `grant_o` with that requester's one-hot code, clear `cnt` and `idl`, and go to `GRANT`.
  - If no request is valid, stay in `IDLE`.
- **GRANT, for granted requester g:**
  - `in_data_o = req_data_i[g]` and `in_valid_o = req_valid_i[g]`.
  - `req_ready_o[g] = in_ready_i`; all other bits of `req_ready_o` are 0.
  - A transfer is a cycle where `in_valid_o & in_ready_i`; each transfer increments `cnt`.
- **Release:** return to `IDLE` with `ptr = g` and `grant_o = 0` on the edge after any of the following:
  - a transfer with `req_last_i[g]` high;
  - a transfer that brings `cnt` to `MAX_BURST`;
  - `idl` reaching `IDLE_CYCLES`, when `IDLE_CYCLES > 0`.
- **Idle counter:**
  - `idl` clears on any cycle where `req_valid_i[g]` is high.
  - Otherwise `idl` increments, saturating.
  - `idl` is not advanced by cycles where `valid` is high but `ready` is low (the stall belongs to `usb_cdc`).
- **Simultaneous events:**
  - `last` together with `cnt` reaching `MAX_BURST` produces one release.
  - A timeout cannot coincide with a transfer, because a transfer requires `valid` high, which clears `idl`.
- **Outside GRANT:** `in_valid_o = 0`, `in_data_o = 8'h00`, `req_ready_o = 0`. `in_ready_i` is ignored.
- **Fairness:** the requester granted most recently has the lowest priority at the next arbitration. A requester that is alone is regranted after one `IDLE` cycle.
- **Requester contract:**
  - A requester must not change data or drop `valid` while `valid & ~ready`.
  - If it does anyway, the arbiter neither detects nor corrects the violation; it keeps forwarding whatever is presented.

## Timing
- **Reset values:** `grant_o = 0`, `busy_o = 0`, `in_valid_o = 0`, `in_data_o = 0`, `req_ready_o = 0`, `ptr = N_REQ-1` (so requester 0 wins first), `cnt = 0`, `idl = 0`, state `IDLE`.
- **Reset mid-burst:** at the `rst_i` edge all state clears. Outputs are idle from that edge onward, and the partial burst is abandoned without a `last`.
- **Request-to-grant latency:** `req_valid_i[k]` rising in cycle t while the block is `IDLE` gives `grant_o[k]` in cycle t+1, and the first transfer is possible in cycle t+1.
- **Burst-to-burst gap:** after the release edge, one `IDLE` cycle, then the next grant. The minimum gap between bursts is 1 cycle with no transfer.
- **Throughput:** one byte per cycle within a burst while `in_ready_i` is high.
- **Combinational paths:**
  - `in_valid_o` and `in_data_o` are combinational from `grant_o` and the `req_*_i` inputs.
  - `req_ready_o` is combinational from `in_ready_i` and `grant_o`.
  - There is no path from `req_valid_i` to `req_ready_o`.

## Test plan
- **Reset and single burst:** after reset, assert `req_valid_i = 2'b01` with 3 bytes `A1 A2 A3`, `last` on `A3`, and `in_ready_i = 1`.
  - Required: `grant_o = 01` one cycle after `valid`, then 3 consecutive transfers.
  - `grant_o = 00` on the cycle after `A3`.
- **Round-robin:** keep both requesters valid continuously with 2-byte bursts.
  - Required: grants alternate 0,1,0,1 with a 1-cycle gap between bursts.
  - Bytes are never interleaved within a burst.
- **MAX_BURST cut:** requester 1 streams 20 bytes with no `last`, `MAX_BURST = 8`.
  - Required: releases after bytes 8 and 16, with requester 1 regranted each time because it is alone.
  - The remaining 4 bytes go in a third burst.
- **Backpressure:** drive `in_ready_i` low for 10 cycles mid-burst.
  - Required: `in_valid_o` stays 1 and `in_data_o` stays stable.
  - `cnt` does not advance and no timeout occurs.
  - Transfers resume on the cycle `in_ready_i` returns high.
- **Idle timeout:** `IDLE_CYCLES = 4`; requester 0 sends 1 byte without `last`, then drops `valid` while requester 1 is valid.
  - Required: `grant_o[0]` clears after 4 idle cycles.
  - `grant_o` becomes `10` one cycle later.
- **Reset mid-burst:** pulse `rst_i` for 1 cycle during the 3rd byte of a burst.
  - Required: all outputs are 0 the cycle after the reset edge.
  - The next arbitration grants requester 0 first.
